// File: rtl/fft_reorder_if.sv
// Streaming bundle around the FFT reorder buffer: bit-reversed input stream in,
// natural-order stream out with bin index, frame-last and abort markers.
interface fft_reorder_if #(
   parameter int N     = 64,
   parameter int WIDTH = 16
);
   localparam int LOG_N = $clog2(N);

   logic             di_en;
   logic [WIDTH-1:0] di_re;
   logic [WIDTH-1:0] di_im;
   logic             do_en;
   logic [WIDTH-1:0] do_re;
   logic [WIDTH-1:0] do_im;
   logic [LOG_N-1:0] do_idx;
   logic             do_last;
   logic             abort;

   modport master (
      output di_en, di_re, di_im,
      input  do_en, do_re, do_im, do_idx, do_last, abort
   );

   modport slave (
      input  di_en, di_re, di_im,
      output do_en, do_re, do_im, do_idx, do_last, abort
   );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong frame buffer that turns the bit-reversed output of the last SDF stage
// into natural bin order; one bank fills while the other drains.
module fft_reorder #(
   parameter int N     = 64,
   parameter int WIDTH = 16
) (
   input  logic         clock,
   input  logic         reset,
   fft_reorder_if.slave bus
);
   localparam int LOG_N = $clog2(N);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_READ = 1'b1;
   localparam logic [LOG_N-1:0] LAST_CNT = LOG_N'(N - 1);

   // Both banks live in one array; the bank select is the address MSB.
   logic [2*WIDTH-1:0] mem [0:2*N-1];
   logic [2*WIDTH-1:0] rd_data_q;

   logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic [1:0]       bank_full_q, bank_full_d;
   logic             abort_q, abort_d;
   logic [0:0]       rd_state_q, rd_state_d;
   logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
   logic             rd_bank_q, rd_bank_d;
   logic             do_en_q, do_en_d;
   logic [LOG_N-1:0] do_idx_q, do_idx_d;
   logic             do_last_q, do_last_d;

   logic [LOG_N-1:0] wr_addr;
   logic             wr_done;
   logic             rd_go;
   logic             rd_done;

   genvar gi;
   generate
      for (gi = 0; gi < LOG_N; gi++) begin : g_bitrev
         assign wr_addr[gi] = wr_cnt_q[LOG_N-1-gi];
      end
   endgenerate

   always_comb begin
      wr_done = bus.di_en && (wr_cnt_q == LAST_CNT);
      // A full bank seen while idle is read at address 0 in the same cycle,
      // which is what keeps back-to-back frames free of bubbles.
      rd_go   = (rd_state_q == ST_READ) || bank_full_q[rd_bank_q];
      rd_done = rd_go && (rd_cnt_q == LAST_CNT);

      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      abort_d   = 1'b0;
      if (bus.di_en) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_done) begin
            wr_bank_d = ~wr_bank_q;
            abort_d   = bank_full_q[wr_bank_q] && !(rd_done && (rd_bank_q == wr_bank_q));
         end
      end else if (wr_cnt_q != '0) begin
         wr_cnt_d = '0;
         abort_d  = 1'b1;
      end

      bank_full_d = bank_full_q;
      rd_state_d  = rd_state_q;
      rd_cnt_d    = rd_cnt_q;
      rd_bank_d   = rd_bank_q;
      if (rd_go) begin
         rd_cnt_d   = rd_cnt_q + 1'b1;
         rd_state_d = ST_READ;
         if (rd_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_state_d             = bank_full_q[~rd_bank_q] ? ST_READ : ST_IDLE;
         end
      end
      if (wr_done) begin
         bank_full_d[wr_bank_q] = 1'b1;
      end

      do_en_d   = rd_go;
      do_idx_d  = rd_go ? rd_cnt_q : '0;
      do_last_d = rd_done;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         bank_full_q <= 2'b00;
         abort_q     <= 1'b0;
         rd_state_q  <= ST_IDLE;
         rd_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         do_en_q     <= 1'b0;
         do_idx_q    <= '0;
         do_last_q   <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         bank_full_q <= bank_full_d;
         abort_q     <= abort_d;
         rd_state_q  <= rd_state_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_bank_q   <= rd_bank_d;
         do_en_q     <= do_en_d;
         do_idx_q    <= do_idx_d;
         do_last_q   <= do_last_d;
      end
   end

   always_ff @(posedge clock) begin
      if (bus.di_en) begin
         mem[{wr_bank_q, wr_addr}] <= {bus.di_re, bus.di_im};
      end
      rd_data_q <= mem[{rd_bank_q, rd_cnt_q}];
   end

   // Read data is not reset, so the valid flag gates it to zero.
   assign bus.do_en   = do_en_q;
   assign bus.do_re   = do_en_q ? rd_data_q[2*WIDTH-1:WIDTH] : '0;
   assign bus.do_im   = do_en_q ? rd_data_q[WIDTH-1:0] : '0;
   assign bus.do_idx  = do_idx_q;
   assign bus.do_last = do_last_q;
   assign bus.abort   = abort_q;
endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder (N=8): frames go in bit-reversed, a scoreboard
// holds the natural-order result with its expected output cycle.
module tb_fft_reorder;
   localparam int N = 8;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [2:0]   idx;
      logic         last;
      int           cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_asserts = 0;
   int   n_fail = 0;
   int   abort_cyc = -1;
   exp_t sb_q [$];
   exp_t mon_e;
   logic [W-1:0] fr_re [N];
   logic [W-1:0] fr_im [N];
   logic hit;

   fft_reorder_if #(.N(N), .WIDTH(W)) bus ();

   fft_reorder #(.N(N), .WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int bitrev3(input int v);
      return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
   endfunction

   task automatic send_frame();
      exp_t e;
      int   tl;
      for (int p = 0; p < N; p++) begin
         @(posedge clock); #1;
         bus.di_en = 1'b1;
         bus.di_re = fr_re[bitrev3(p)];
         bus.di_im = fr_im[bitrev3(p)];
      end
      tl = cyc;
      for (int k = 0; k < N; k++) begin
         e.re   = fr_re[k];
         e.im   = fr_im[k];
         e.idx  = 3'(k);
         e.last = (k == N - 1);
         e.cyc  = tl + 2 + k;
         sb_q.push_back(e);
      end
      $display("frame queued: last input cycle %0d, bins 0..7 expected from cycle %0d", tl, tl + 2);
   endtask

   task automatic send_partial(input int n);
      for (int p = 0; p < n; p++) begin
         @(posedge clock); #1;
         bus.di_en = 1'b1;
         bus.di_re = 16'hDEAD;
         bus.di_im = 16'hBEEF;
      end
      abort_cyc = cyc + 2;
      $display("partial frame of %0d samples, abort expected at cycle %0d", n, abort_cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         bus.di_en = 1'b0;
         bus.di_re = '0;
         bus.di_im = '0;
      end
   endtask

   // Output monitor: every valid beat is popped against the scoreboard; idle
   // beats must be all-zero; abort must pulse only on the predicted cycle.
   always @(negedge clock) begin
      chk("abort", 64'(bus.abort), 64'(cyc == abort_cyc));
      if (bus.do_en === 1'b1) begin
         chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("do_re", 64'(bus.do_re), 64'(mon_e.re));
            chk("do_im", 64'(bus.do_im), 64'(mon_e.im));
            chk("do_idx", 64'(bus.do_idx), 64'(mon_e.idx));
            chk("do_last", 64'(bus.do_last), 64'(mon_e.last));
            chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
            $display("out cyc=%0d idx=%0d re=%h im=%h last=%0b", cyc, bus.do_idx, bus.do_re, bus.do_im, bus.do_last);
         end
      end else begin
         chk("idle_zero", 64'({bus.do_en, bus.do_re, bus.do_im, bus.do_idx, bus.do_last}), 64'd0);
      end
   end

   initial begin
      bus.di_en = 1'b0;
      bus.di_re = '0;
      bus.di_im = '0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_state", 64'({bus.do_en, bus.do_re, bus.do_im, bus.do_idx, bus.do_last, bus.abort}), 64'd0);
      reset = 1'b1;
      idle(3);

      // Single frame: re = bin, im = -bin
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(k);
         fr_im[k] = 16'(0 - k);
      end
      send_frame();
      idle(12);

      // Three back-to-back frames
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < N; k++) begin
            fr_re[k] = 16'(8 * f + k);
            fr_im[k] = 16'(0 - (8 * f + k));
         end
         send_frame();
      end
      idle(12);

      // Truncated frame followed by a full one
      send_partial(5);
      idle(4);
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(100 + k);
         fr_im[k] = 16'(3 * k);
      end
      send_frame();
      idle(12);

      // Gapped frames
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(16'h0200 + k);
         fr_im[k] = 16'(16'h0300 - k);
      end
      send_frame();
      idle(10);
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(16'h0400 + 7 * k);
         fr_im[k] = 16'(16'h0500 ^ k);
      end
      send_frame();
      idle(12);

      // Sign and full-range values
      fr_re = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h0000, 16'h7FFE, 16'h8001, 16'h5A5A};
      fr_im = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'hA5A5, 16'h0000, 16'hFFFE, 16'h8001};
      send_frame();
      idle(12);

      // Reset while bin 3 is on the output
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(16'h0600 + k);
         fr_im[k] = 16'(16'h0700 + k);
      end
      send_frame();
      idle(1);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(posedge clock); #1;
         if (bus.do_en === 1'b1 && bus.do_idx === 3'd3) hit = 1'b1;
      end
      chk("wait_bin3", 64'(hit), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("midrst_do_en", 64'(bus.do_en), 64'd0);
      chk("midrst_outputs", 64'({bus.do_re, bus.do_im, bus.do_idx, bus.do_last, bus.abort}), 64'd0);
      $display("reset asserted mid-readout at cycle %0d, %0d queued beats dropped", cyc, sb_q.size());
      sb_q.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      idle(20);
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(16'h0800 + 5 * k);
         fr_im[k] = 16'(16'h0900 - 5 * k);
      end
      send_frame();
      idle(14);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
